instr_mem_loader: RTL
=====================

Name: instr_mem_loader

Overview:
- Parametrised instruction memory for the MIPS datapath, replacing the fixed hard-coded program store.
- Programs are loaded at run time through a byte-serial loader port with a valid/ready handshake. Bytes are assembled big-endian into words.
- Instruction fetch goes through a registered port with one-cycle latency and misalignment/range fault reporting.
- Fetches beyond the loaded program length return 32'h0 (NOP).

Parameters:
- ADDR_WIDTH, 32, width of the fetch byte address.
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).
- DEPTH_WORDS, 256, number of instruction words stored.
- LEN_WIDTH, 9, width of the program-length counter; must satisfy 2^LEN_WIDTH > DEPTH_WORDS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  high requests and holds load mode; falling edge ends the load.
- load_valid  input  1  load_byte is valid this cycle.
- load_byte  input  8  program byte, most significant byte of each word first.
- load_ready  output  1  loader can accept a byte this cycle.
- load_done  output  1  one-cycle pulse when a load completes.
- load_overflow  output  1  sticky; a byte was offered while memory was full.
- fetch_req  input  1  fetch request, sampled on the clock edge.
- address  input  ADDR_WIDTH  fetch byte address.
- data_out  output  DATA_WIDTH  registered instruction word.
- data_valid  output  1  one-cycle pulse, data_out is valid.
- addr_fault  output  1  one-cycle pulse with data_valid on a bad fetch.
- prog_len  output  LEN_WIDTH  number of words loaded.

Behaviour:
- Reset (asynchronous, any state, including mid-load):
  - State goes to IDLE.
  - load_ready, load_done, load_overflow, data_valid, addr_fault = 0.
  - data_out = 0, prog_len = 0, write pointer = 0, byte count = 0.
  - Array contents are not cleared. prog_len = 0 makes old contents invisible.
- States are IDLE, LOAD, FLUSH, RUN.
  - IDLE: load_en=1 moves to LOAD next cycle. Fetches are serviced (all return 0, since prog_len=0).
  - LOAD:
    - On entry: write pointer = 0, byte count = 0, prog_len = 0, load_overflow cleared.
    - load_ready = 1 while write pointer < DEPTH_WORDS.
    - A byte is accepted when load_valid && load_ready. It shifts into the assembly register MSB-first.
    - On the 4th byte, the word is written to mem[wptr] in the same edge, wptr increments, prog_len = wptr+1, byte count returns to 0.
    - When wptr == DEPTH_WORDS, load_ready = 0. A load_valid in this condition sets load_overflow, and the byte is dropped.
    - load_en=0 with byte count = 0 moves to RUN.
    - load_en=0 with byte count != 0 moves to FLUSH.
    - fetch_req is ignored in LOAD: no data_valid, no fault.
  - FLUSH: the partial word is left-aligned, zero-padded in the low bytes, and written to mem[wptr]. prog_len increments. Next state is RUN. Takes one cycle.
  - RUN: fetches are serviced. load_en=1 moves to LOAD (reprogramming). A fetch_req in that same cycle is still serviced.
- load_done pulses exactly one cycle on the first RUN cycle after a LOAD or FLUSH.
- Fetch (IDLE and RUN states), with word index = address[ADDR_WIDTH-1:2]:
  - fetch_req=1 at edge N gives data_valid=1 at edge N+1 (one-cycle latency). Back-to-back requests give back-to-back results.
  - If address[1:0] != 0, or index >= DEPTH_WORDS: addr_fault=1, data_out=0.
  - Else if index >= prog_len: data_out=0 (NOP), addr_fault=0.
  - Else: data_out = mem[index].
  - With no request, data_out holds its last value and data_valid=0.
- A simultaneous final byte and load_en fall is legal: the byte is accepted and the word written; the next state is RUN (byte count is 0 after the write).

Test Plan:
- Reset, then fetch address 0 -> data_valid=1 one cycle later, data_out=32'h0, addr_fault=0, prog_len=0.
- Load bytes 8D 10 02 00 8D 30 03 00, then drop load_en -> load_done pulse, prog_len=2. Fetch 0 returns 32'h8D100200; fetch 4 returns 32'h8D300300; fetch 8 returns 32'h0.
- Fetch address 6 after the above -> addr_fault=1, data_out=0. Fetch 4*DEPTH_WORDS -> addr_fault=1.
- Load 6 bytes AA BB CC DD 11 22, then drop load_en -> FLUSH. prog_len=2; word 1 = 32'h11220000.
- Offer DEPTH_WORDS*4+1 bytes -> load_ready falls after the last word, load_overflow=1, prog_len=DEPTH_WORDS, last word intact.
- Assert reset after 3 bytes of a reload -> prog_len=0, state IDLE, fetch 0 returns 0. A fresh load then succeeds.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Run-time loadable instruction memory: a byte-serial loader assembles big-endian
// words into the array, and a registered fetch port serves them with fault reporting.
module instr_mem_loader #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LEN_WIDTH   = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  load_overflow,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  addr_fault,
  output logic [LEN_WIDTH-1:0]  prog_len
);

  localparam int IDX_WIDTH = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [LEN_WIDTH-1:0]  DEPTH_LEN = LEN_WIDTH'(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-3:0] DEPTH_IDX = (ADDR_WIDTH-2)'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t                  state, state_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
  logic [LEN_WIDTH-1:0]    wptr;
  logic [1:0]              bcnt;
  logic [23:0]             asm_q;
  logic                    accept;
  logic                    word_done;
  logic [DATA_WIDTH-1:0]   flush_word;
  logic [ADDR_WIDTH-3:0]   fetch_idx;
  logic                    fetch_ok;
  logic                    idx_fault;
  logic                    idx_beyond;

  // Loader handshake: a byte moves when load_valid && load_ready on the same edge.
  always_comb begin
    state_next = state;
    load_ready = (state == LOAD) && (wptr < DEPTH_LEN);
    accept     = load_ready && load_valid;
    word_done  = accept && (bcnt == 2'd3);
    case (state)
      IDLE, RUN: if (load_en) state_next = LOAD;
      LOAD: begin
        // Byte count after this edge decides whether a partial word needs flushing.
        if (!load_en)
          state_next = ((bcnt == 2'd0 && !accept) || word_done) ? RUN : FLUSH;
      end
      FLUSH:     state_next = RUN;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    case (bcnt)
      2'd1:    flush_word = {asm_q[7:0], 24'h0};
      2'd2:    flush_word = {asm_q[15:0], 16'h0};
      2'd3:    flush_word = {asm_q, 8'h0};
      default: flush_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wptr          <= '0;
      bcnt          <= '0;
      asm_q         <= '0;
      prog_len      <= '0;
      load_overflow <= 1'b0;
      load_done     <= 1'b0;
    end else begin
      state     <= state_next;
      load_done <= (state_next == RUN) && (state == LOAD || state == FLUSH);
      if (state_next == LOAD && state != LOAD) begin
        wptr          <= '0;
        bcnt          <= '0;
        prog_len      <= '0;
        load_overflow <= 1'b0;
      end
      if (state == LOAD) begin
        if (load_valid && !load_ready) load_overflow <= 1'b1;
        if (accept) begin
          asm_q <= {asm_q[15:0], load_byte};
          bcnt  <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            wptr     <= wptr + 1'b1;
            prog_len <= wptr + 1'b1;
          end
        end
      end
      if (state == FLUSH) begin
        wptr     <= wptr + 1'b1;
        prog_len <= wptr + 1'b1;
        bcnt     <= '0;
      end
    end
  end

  // The array is deliberately left out of reset; prog_len hides stale words.
  always_ff @(posedge clk) begin
    if (word_done)
      mem[wptr[IDX_WIDTH-1:0]] <= {asm_q, load_byte};
    else if (state == FLUSH)
      mem[wptr[IDX_WIDTH-1:0]] <= flush_word;
  end

  assign fetch_idx  = address[ADDR_WIDTH-1:2];
  assign idx_fault  = (address[1:0] != 2'b00) || (fetch_idx >= DEPTH_IDX);
  assign idx_beyond = fetch_idx >= (ADDR_WIDTH-2)'(prog_len);
  assign fetch_ok   = fetch_req && (state == IDLE || state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      addr_fault <= 1'b0;
    end else begin
      data_valid <= fetch_ok;
      addr_fault <= fetch_ok && idx_fault;
      if (fetch_ok)
        data_out <= (idx_fault || idx_beyond) ? '0 : mem[fetch_idx[IDX_WIDTH-1:0]];
    end
  end

endmodule
